// File: rtl/cricket_pkg.sv
// Shared outcome codes, FSM states and result encodings for the cricket game blocks.
package cricket_pkg;

    localparam logic [3:0] OUT_DOT  = 4'd0;
    localparam logic [3:0] OUT_NB   = 4'd5;
    localparam logic [3:0] OUT_SIX  = 4'd6;
    localparam logic [3:0] OUT_WIDE = 4'd7;
    localparam logic [3:0] OUT_WKT  = 4'd8;

    localparam int unsigned BALLS_PER_OVER = 6;

    typedef enum logic [2:0] {
        IDLE,
        INN1,
        BREAK,
        INN2,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'b00,
        RES_SIDE1 = 2'b01,
        RES_SIDE2 = 2'b10,
        RES_TIE   = 2'b11
    } result_t;

endpackage

// File: rtl/ball_edge_det.sv
// Two-flop synchronizer for an asynchronous button level plus a one-cycle rising-edge pulse.
module ball_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign pulse = sync2 & ~hist;

endmodule

// File: rtl/innings_scorer.sv
// Two-innings cricket scorer driven by debounced bowl presses and random outcome codes.
// Optional macro FREE_HIT_EN: a wicket on the legal ball after a no-ball is scored as a dot.
module innings_scorer
    import cricket_pkg::*;
#(
    parameter int unsigned OVERS    = 2,
    parameter int unsigned MAX_WKTS = 10,
    parameter int unsigned SCORE_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ball_sw,
    input  logic [3:0]         lfsr_out,
    output logic               game_over,
    output logic               innings,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         wickets,
    output logic [2:0]         balls,
    output logic [4:0]         overs,
    output logic [SCORE_W-1:0] target,
    output logic [3:0]         last_outcome,
    output logic               ball_valid,
    output logic [1:0]         result
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic ball_evt;

    ball_edge_det u_edge (
        .clk   (clk),
        .rst   (rst),
        .din   (ball_sw),
        .pulse (ball_evt)
    );

    state_t             state_q, state_d;
    result_t            result_d;
    logic               innings_d, ball_valid_d;
    logic [SCORE_W-1:0] score_d, target_d;
    logic [3:0]         wickets_d, last_d;
    logic [2:0]         balls_d;
    logic [4:0]         overs_d;

    logic [3:0]         code, runs;
    logic               legal, take_wkt, inn_end;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] sc_upd;
    logic [3:0]         wk_upd;
    logic [2:0]         balls_upd;
    logic [4:0]         overs_upd;

`ifdef FREE_HIT_EN
    logic free_hit_q, free_hit_d;
`endif

    // Post-update values of one ball; both innings states commit these.
    always_comb begin
        code = (lfsr_out > OUT_WKT) ? OUT_DOT : lfsr_out;
        case (code)
            4'd1, 4'd2, 4'd3, 4'd4, OUT_SIX: runs = code;
            OUT_NB, OUT_WIDE:                runs = 4'd1;
            default:                         runs = 4'd0;
        endcase
        legal    = !(code == OUT_NB || code == OUT_WIDE);
`ifdef FREE_HIT_EN
        take_wkt = (code == OUT_WKT) && !free_hit_q;
`else
        take_wkt = (code == OUT_WKT);
`endif
        sum    = {1'b0, score} + (SCORE_W+1)'(runs);
        sc_upd = sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
        wk_upd = (take_wkt && wickets < 4'(MAX_WKTS)) ? wickets + 4'd1 : wickets;
        balls_upd = balls;
        overs_upd = overs;
        if (legal) begin
            if (balls == 3'(BALLS_PER_OVER - 1)) begin
                balls_upd = 3'd0;
                overs_upd = overs + 5'd1;
            end else begin
                balls_upd = balls + 3'd1;
            end
        end
        inn_end = (wk_upd == 4'(MAX_WKTS)) || (overs_upd == 5'(OVERS));
    end

    always_comb begin
        state_d      = state_q;
        result_d     = result_t'(result);
        innings_d    = innings;
        score_d      = score;
        wickets_d    = wickets;
        balls_d      = balls;
        overs_d      = overs;
        target_d     = target;
        last_d       = last_outcome;
        ball_valid_d = 1'b0;
`ifdef FREE_HIT_EN
        free_hit_d   = free_hit_q;
`endif
        case (state_q)
            IDLE:  if (ball_evt) state_d = INN1;
            BREAK: if (ball_evt) state_d = INN2;
            INN1, INN2: begin
                if (ball_evt) begin
                    ball_valid_d = 1'b1;
                    last_d       = code;
                    score_d      = sc_upd;
                    wickets_d    = wk_upd;
                    balls_d      = balls_upd;
                    overs_d      = overs_upd;
`ifdef FREE_HIT_EN
                    if (code == OUT_NB)
                        free_hit_d = 1'b1;
                    else if (legal)
                        free_hit_d = 1'b0;
`endif
                    if (state_q == INN1) begin
                        if (inn_end) begin
                            target_d  = (sc_upd == SCORE_MAX) ? SCORE_MAX : sc_upd + SCORE_W'(1);
                            score_d   = '0;
                            wickets_d = '0;
                            balls_d   = '0;
                            overs_d   = '0;
                            innings_d = 1'b1;
                            state_d   = BREAK;
                        end
                    end else if (sc_upd >= target) begin
                        result_d = RES_SIDE2;
                        state_d  = DONE;
                    end else if (inn_end) begin
                        result_d = (sc_upd == target - SCORE_W'(1)) ? RES_TIE : RES_SIDE1;
                        state_d  = DONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            result       <= RES_NONE;
            innings      <= 1'b0;
            score        <= '0;
            wickets      <= '0;
            balls        <= '0;
            overs        <= '0;
            target       <= '0;
            last_outcome <= '0;
            ball_valid   <= 1'b0;
        end else begin
            state_q      <= state_d;
            result       <= result_d;
            innings      <= innings_d;
            score        <= score_d;
            wickets      <= wickets_d;
            balls        <= balls_d;
            overs        <= overs_d;
            target       <= target_d;
            last_outcome <= last_d;
            ball_valid   <= ball_valid_d;
        end
    end

`ifdef FREE_HIT_EN
    always_ff @(posedge clk) begin
        if (rst) free_hit_q <= 1'b0;
        else     free_hit_q <= free_hit_d;
    end
`endif

    assign game_over = (state_q == DONE);

endmodule

// File: tb/tb_innings_scorer.sv
// Directed self-checking bench for innings_scorer (OVERS=2, MAX_WKTS=10, SCORE_W=10).
module tb_innings_scorer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ball_sw = 1'b0;
    logic [3:0] lfsr_out = 4'd0;
    logic       game_over, innings, ball_valid;
    logic [9:0] score, target;
    logic [3:0] wickets, last_outcome;
    logic [2:0] balls;
    logic [4:0] overs;
    logic [1:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    int vcount   = 0;
    int vsnap;

    innings_scorer #(.OVERS(2), .MAX_WKTS(10), .SCORE_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .ball_sw      (ball_sw),
        .lfsr_out     (lfsr_out),
        .game_over    (game_over),
        .innings      (innings),
        .score        (score),
        .wickets      (wickets),
        .balls        (balls),
        .overs        (overs),
        .target       (target),
        .last_outcome (last_outcome),
        .ball_valid   (ball_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ball_valid) vcount++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ball_sw = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        lfsr_out = code;
        ball_sw  = 1'b1;
        repeat (4) @(negedge clk);
        ball_sw  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press_n(input logic [3:0] code, input int n);
        for (int i = 0; i < n; i++) press(code);
    endtask

    // First innings of 4 runs over 12 legal balls, then start of innings 2 chasing 5.
    task automatic setup_target5();
        do_reset();
        press(4'd0);
        press(4'd4);
        press_n(4'd0, 11);
        check("t5_target", target, 5);
        check("t5_innings", innings, 1);
        press(4'd0);
    endtask

    initial begin
        // Game 1: runs, extras, over rollover, out-of-range code, chase win.
        do_reset();
        check("rst_score", score, 0);
        check("rst_misc", {game_over, innings, wickets, balls, overs, last_outcome, ball_valid, result}, 0);
        check("rst_target", target, 0);
        press(4'd0);
        check("start_not_applied", vcount, 0);
        press(4'd4); press(4'd6); press(4'd1);
        check("g1_score11", score, 11);
        check("g1_balls3", balls, 3);
        check("g1_overs0", overs, 0);
        check("g1_valid3", vcount, 3);
        check("g1_last1", last_outcome, 1);
        press(4'd7); press(4'd5);
        check("g1_extras_score", score, 13);
        check("g1_extras_balls", balls, 3);
        check("g1_last_nb", last_outcome, 5);
        press(4'd12);
        check("g1_code12_score", score, 13);
        check("g1_code12_balls", balls, 4);
        check("g1_code12_last", last_outcome, 0);
        press_n(4'd0, 2);
        check("g1_over_balls", balls, 0);
        check("g1_over_overs", overs, 1);
        press_n(4'd0, 5);
        check("g1_b5", balls, 5);
        check("g1_inn1_live", innings, 0);
        press(4'd0);
        check("g1_break_innings", innings, 1);
        check("g1_break_target", target, 14);
        check("g1_break_clear", {score, wickets, balls, overs}, 0);
        check("g1_break_go", game_over, 0);
        check("g1_valid14", vcount, 14);
        press(4'd0);
        check("g1_inn2_start", vcount, 14);
        press(4'd6); press(4'd6); press(4'd1);
        check("g1_13_no_result", result, 0);
        check("g1_13_score", score, 13);
        press(4'd1);
        check("g1_win_result", result, 2'b10);
        check("g1_win_go", game_over, 1);
        check("g1_win_score", score, 14);
        vsnap = vcount;
        press(4'd6);
        check("g1_done_score", score, 14);
        check("g1_done_novalid", vcount, vsnap);

        // Game 2: all-out at MAX_WKTS in both innings, tie on 0 vs target 1.
        do_reset();
        press(4'd0);
        press_n(4'd8, 9);
        check("g2_wk9", wickets, 9);
        check("g2_wk9_balls", {overs, balls}, {5'd1, 3'd3});
        press(4'd8);
        check("g2_allout_innings", innings, 1);
        check("g2_allout_target", target, 1);
        check("g2_allout_wk", wickets, 0);
        press(4'd0);
        press_n(4'd8, 10);
        check("g2_tie_result", result, 2'b11);
        check("g2_tie_wk", wickets, 10);
        check("g2_tie_go", game_over, 1);

        // Game 3: side 1 wins when chase ends two short.
        setup_target5();
        press(4'd3);
        press_n(4'd8, 9);
        check("g3_wk9_result", result, 0);
        press(4'd8);
        check("g3_side1_result", result, 2'b01);
        check("g3_side1_score", score, 3);
        check("g3_side1_go", game_over, 1);

        // Game 4: rst coincides with a ball event in innings 2.
        setup_target5();
        press(4'd3);
        check("g4_pre_score", score, 3);
        vsnap = vcount;
        @(negedge clk);
        lfsr_out = 4'd6;
        ball_sw  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("g4_rst_score", score, 0);
        check("g4_rst_target", target, 0);
        check("g4_rst_misc", {game_over, innings, wickets, balls, overs, last_outcome, ball_valid, result}, 0);
        check("g4_rst_novalid", vcount, vsnap);
        repeat (4) @(negedge clk);
        ball_sw = 1'b0;
        repeat (4) @(negedge clk);
        press(4'd2);
        check("g4_restart_score", score, 2);
        check("g4_restart_innings", innings, 0);

`ifdef FREE_HIT_EN
        do_reset();
        press(4'd0);
        press(4'd5);
        press(4'd7);
        press(4'd8);
        check("fh_wk", wickets, 0);
        check("fh_balls", balls, 1);
        check("fh_score", score, 2);
        press(4'd8);
        check("fh_cleared_wk", wickets, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d/%0d expected run to finish", n_pass, n_checks);
        $fatal(1);
    end

endmodule
